// File: rtl/instruction_loader.sv
// Instruction loader: turns a received byte stream into instruction memory writes.
//
// Stream: 4-byte big-endian word count N, then N words of 4 bytes each, big-endian.
// Each completed word produces a one-cycle write strobe in the cycle after its last
// byte. The first write goes to address 0, and each later write goes to the next address.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one trailing byte equal to the
// XOR of all data bytes. A mismatch ends in ERROR. Words already written stay written.
//
// Parameters:
//   MEM_SIZE         maximum accepted word count
//   ADDR_WIDTH       width of mem_address
// Ports:
//   clk              clock, rising edge
//   reset            synchronous active-high reset
//   start            re-arms the loader from DONE or ERROR; ignored elsewhere
//   rx_valid/rx_data received byte strobe and byte
//   mem_write_enable one-cycle write strobe
//   mem_address      word address of the write (held between writes)
//   mem_write_data   word being written (held between writes)
//   loading          high in COUNT or DATA
//   done             high in DONE
//   error            high in ERROR
module instruction_loader #(
    parameter int unsigned MEM_SIZE   = 20000,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  loading,
    output logic                  done,
    output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StCount, StData, StCheck, StDone, StError} state_e;
`else
    typedef enum logic [1:0] {StCount, StData, StDone, StError} state_e;
`endif

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;     // upper three bytes of the word in flight
    logic [31:0]           count_q, count_d;     // latched word count N
    logic [31:0]           words_q, words_d;     // words completed so far
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           word_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign word_full = {shift_q, rx_data};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        count_d    = count_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StCount: begin
                if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = word_full[23:0];
                    if (byte_cnt_q == 2'd3) begin
                        count_d = word_full;
                        if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = StCheck;
`else
                            state_d = StDone;
`endif
                        end else if (word_full > MEM_SIZE) begin
                            state_d = StError;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (words_q == count_q) begin
                    // Last write strobe is active this cycle; leave DATA next cycle.
`ifdef LOADER_CHECKSUM_EN
                    // A checksum byte arriving right behind the last word is taken here.
                    if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? StDone : StError;
                    end else begin
                        state_d = StCheck;
                    end
`else
                    state_d = StDone;
`endif
                end else if (rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = word_full[23:0];
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word_full;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        words_d = words_q + 32'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? StDone : StError;
                end
            end
`endif
            StDone, StError: begin
                if (start) begin
                    state_d    = StCount;
                    byte_cnt_d = 2'd0;
                    shift_d    = 24'd0;
                    words_d    = 32'd0;
                    addr_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            default: state_d = StCount;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCount;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            count_q    <= 32'd0;
            words_q    <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            words_q    <= words_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign mem_write_enable = we_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign loading          = (state_q == StCount) || (state_q == StData);
    assign done             = (state_q == StDone);
    assign error            = (state_q == StError);

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The module SHALL have parameter MEM_SIZE, default 20000, meaning the maximum word count accepted.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 16, meaning the width of mem_address.
REQ-003 clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that re-arms the loader from DONE or ERROR.
REQ-006 rx_valid  input  1  one-cycle strobe marking rx_data as a new received byte.
REQ-007 rx_data  input  8  received byte.
REQ-008 mem_write_enable  output  1  one-cycle write strobe to the instruction memory.
REQ-009 mem_address  output  ADDR_WIDTH  word address of the current write.
REQ-010 mem_write_data  output  32  word being written.
REQ-011 loading  output  1  high while in the COUNT or DATA state.
REQ-012 done  output  1  high while in the DONE state.
REQ-013 error  output  1  high while in the ERROR state.

Function
REQ-014 The stream format SHALL be a 4-byte big-endian word count N, followed by N words, each sent as 4 bytes, big-endian.
REQ-015 The states SHALL be COUNT, DATA, (CHECK), DONE and ERROR.
REQ-016 The state after reset SHALL be COUNT.
REQ-017 A byte SHALL be consumed only in a cycle where rx_valid=1; rx_valid is ignored in DONE and ERROR.
REQ-018 In COUNT, bytes SHALL shift in MSB-first; after the 4th byte, N is latched.
REQ-019 After N is latched: N=0 goes to DONE (or CHECK), N>MEM_SIZE goes to ERROR, otherwise DATA.
REQ-020 In DATA, bytes SHALL assemble MSB-first into a 32-bit word.
REQ-021 The cycle after a word's 4th byte is consumed, mem_write_enable SHALL be 1 for exactly one cycle, with the assembled word on mem_write_data and the word index on mem_address.
REQ-022 The first word SHALL be written at address 0, with the address incrementing by 1 after each write.
REQ-023 A byte arriving in the same cycle as a write strobe SHALL be accepted without loss.
REQ-024 After the N-th write, the state SHALL go to DONE (or CHECK) the next cycle.
REQ-025 start in DONE or ERROR SHALL clear the address, the byte counter and the checksum, and enter COUNT; start in any other state is ignored.
REQ-026 mem_address and mem_write_data SHALL hold their last values when no write is in progress.
REQ-027 The byte counter SHALL wrap 3->0; the word address SHALL never exceed N-1.

Reset
REQ-028 reset=1 SHALL force: state COUNT, N=0, byte counter 0, mem_address 0, mem_write_data 0, mem_write_enable 0, loading 1, done 0, error 0, checksum 0.
REQ-029 Reset SHALL take priority over start and rx_valid.
REQ-030 Reset mid-load SHALL abandon the partial word with no write strobe.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN SHALL enable a checksum byte.
REQ-032 With LOADER_CHECKSUM_EN defined: in state CHECK, one more byte is compared with the XOR of all data bytes (count bytes excluded); a match goes to DONE and a mismatch goes to ERROR. Words already written stay written.
REQ-033 Without LOADER_CHECKSUM_EN: the CHECK state and the checksum register SHALL be absent, and COUNT/DATA completion goes straight to DONE.

Verification
REQ-034 Bytes 00 00 00 02, DE AD BE EF, 01 02 03 04 -> writes (0, DEADBEEF) then (1, 01020304), each strobe 1 cycle after its 4th byte; done=1 thereafter.
REQ-035 Count 00 00 00 00 -> no write strobe; done=1 one cycle after the 4th byte; loading=0.
REQ-036 Count 00 00 4E 21 (20001) -> error=1, no writes; then start -> loading=1 and error=0 on the next cycle.
REQ-037 reset asserted after 2 data bytes of word 0, then a full 1-word stream -> the single write is (0, new word) with no stale bytes.
REQ-038 rx_valid on consecutive cycles, 3 words -> 3 strobes at addresses 0,1,2 and no lost bytes.
REQ-039 With LOADER_CHECKSUM_EN, 1 word 11 22 33 44 plus checksum 44 -> done=1; the same with checksum 45 -> error=1, word still written at address 0.
